// File: rtl/imem_loader.sv
// imem_loader: writer side of the word-addressed instruction memory.
// Takes a byte stream (16-bit word count, then 32-bit words LSB first),
// writes each assembled word to consecutive addresses from 0, and raises
// cpu_run once the whole image is in memory.
// Optional feature: define CHECKSUM_EN to expect a trailing XOR byte after
// the last word; a mismatch ends the load in ERROR with err_csum set.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              err_ovf,
  output logic              err_csum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic [15:0]         len_reg;
  logic [1:0]          byte_idx_reg;
  logic [23:0]         asm_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic [ADDR_W:0]     word_cnt_reg;
  logic                err_ovf_reg;

  logic                hs;
  logic [15:0]         len_hdr;
  logic [15:0]         cnt_plus1;
  logic                last_word;
  logic                clr;
  logic                set_ovf;

  // a byte moves only when both sides agree
  assign hs        = in_valid && in_ready;
  // full length as it would be once the HDR1 byte lands
  assign len_hdr   = {in_data, len_reg[7:0]};
  assign cnt_plus1 = 16'(word_cnt_reg) + 16'd1;
  assign last_word = (cnt_plus1 == len_reg);

`ifdef CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       err_csum_reg;
  logic       set_csum;
`endif

  // state register; reset aborts any load in progress immediately
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    clr        = 1'b0;
    set_ovf    = 1'b0;
`ifdef CHECKSUM_EN
    set_csum   = 1'b0;
`endif
    case (state_reg)
      S_IDLE, S_ERROR: begin
        if (start) begin
          clr        = 1'b1;
          state_next = S_HDR0;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clr        = 1'b1;
          state_next = S_HDR0;
        end
      end
      S_HDR0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) state_next = S_HDR1;
      end
      S_HDR1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (len_hdr == 16'd0) begin
            state_next = S_DONE;
          end else if (len_hdr > 16'(DEPTH)) begin
            // rejecting here is what guarantees the address never wraps
            set_ovf    = 1'b1;
            state_next = S_ERROR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && byte_idx_reg == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (!last_word) begin
          state_next = S_DATA;
        end else begin
`ifdef CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (in_data == csum_reg) begin
            state_next = S_DONE;
          end else begin
            set_csum   = 1'b1;
            state_next = S_ERROR;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // header capture, word assembly, write-port registers and word counter
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      byte_idx_reg  <= '0;
      asm_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      word_cnt_reg  <= '0;
      err_ovf_reg   <= 1'b0;
    end else begin
      if (clr) begin
        len_reg      <= '0;
        byte_idx_reg <= '0;
        word_cnt_reg <= '0;
        err_ovf_reg  <= 1'b0;
      end
      if (state_reg == S_HDR0 && hs) len_reg[7:0]  <= in_data;
      if (state_reg == S_HDR1 && hs) len_reg[15:8] <= in_data;
      if (state_reg == S_DATA && hs) begin
        byte_idx_reg <= byte_idx_reg + 2'd1;
        case (byte_idx_reg)
          2'd0: asm_reg[7:0]   <= in_data;
          2'd1: asm_reg[15:8]  <= in_data;
          2'd2: asm_reg[23:16] <= in_data;
          default: begin
            // 4th byte: latch the write port so it holds outside WRITE
            mem_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
            mem_wdata_reg <= {in_data, asm_reg};
          end
        endcase
      end
      if (state_reg == S_WRITE) word_cnt_reg <= word_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};
      if (set_ovf) err_ovf_reg <= 1'b1;
    end
  end

`ifdef CHECKSUM_EN
  // running XOR over data bytes and sticky checksum error
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg     <= '0;
      err_csum_reg <= 1'b0;
    end else begin
      if (clr) begin
        csum_reg     <= '0;
        err_csum_reg <= 1'b0;
      end
      if (state_reg == S_DATA && hs) csum_reg <= csum_reg ^ in_data;
      if (set_csum) err_csum_reg <= 1'b1;
    end
  end
  assign err_csum = err_csum_reg;
`else
  assign err_csum = 1'b0;
`endif

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign word_cnt  = word_cnt_reg;
  assign err_ovf   = err_ovf_reg;
  // DONE is only reachable without an error, so release follows done
  assign cpu_run   = done;

endmodule
